// File: rtl/pump_monitor_pkg.sv
// Shared sensor/alarm indices and fault decode for the pump monitor.
package pump_monitor_pkg;

  localparam int SENS_PWR = 0;
  localparam int SENS_PRS = 1;
  localparam int SENS_LVL = 2;
  localparam int SENS_FLW = 3;
  localparam int SENS_TMP = 4;
  localparam int SENS_VIB = 5;

  localparam int ALM_RUN = 0;
  localparam int ALM_PRS = 1;
  localparam int ALM_LVL = 2;
  localparam int ALM_FLW = 3;
  localparam int ALM_TMP = 4;
  localparam int ALM_VIB = 5;

  localparam int DEB_CNT_W = 8;

  // Live fault conditions, indexed by ALM_*; the ALM_RUN slot is always 0.
  function automatic logic [5:0] alarm_decode(input logic [5:0] f);
    logic [5:0] a;
    logic       pwr;
    pwr        = f[SENS_PWR];
    a          = '0;
    a[ALM_PRS] = pwr & ~f[SENS_PRS];
    a[ALM_LVL] = pwr & ~f[SENS_LVL];
    a[ALM_FLW] = pwr & ~f[SENS_FLW];
    a[ALM_TMP] = pwr &  f[SENS_TMP];
    a[ALM_VIB] = pwr &  f[SENS_VIB];
    return a;
  endfunction

endpackage

// File: rtl/pump_sensor_filter.sv
// One sensor bit: 2-flop synchroniser followed by a consecutive-cycle debounce.
module pump_sensor_filter
  import pump_monitor_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_filt;
  logic [DEB_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= RST_VAL;
      r_sync2 <= RST_VAL;
      r_filt  <= RST_VAL;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_filt) begin
        if (r_cnt == DEB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/industrial_pump_monitor.sv
// Pump fault monitor: six filtered sensors decoded into run-OK plus five alarms.
// Define FAULT_LATCH_EN to make alarms sticky until acknowledged with fault_clr.
module industrial_pump_monitor
  import pump_monitor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic S1,
  input  logic S2,
  input  logic S3,
  input  logic S4,
  input  logic S5,
  input  logic S6,
  input  logic fault_clr,
  output logic A1,
  output logic A2,
  output logic A3,
  output logic A4,
  output logic A5,
  output logic A6
);

  logic [5:0] w_sens;
  logic [5:0] w_filt;
  logic [5:0] w_live;
  logic       w_pwr;
  logic [5:0] r_alm;

  assign w_sens = {S6, S5, S4, S3, S2, S1};

  for (genvar g = 0; g < 6; g++) begin : g_filt
    pump_sensor_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RST_VAL        (1'b0)
    ) u_filt (
      .clk   (clk),
      .rst   (rst),
      .i_raw (w_sens[g]),
      .o_filt(w_filt[g])
    );
  end

  assign w_pwr  = w_filt[SENS_PWR];
  assign w_live = alarm_decode(w_filt);

`ifdef FAULT_LATCH_EN
  logic [5:0] w_latch_nxt;

  // A live condition always wins over an acknowledge in the same cycle.
  assign w_latch_nxt = w_pwr ? (w_live | (r_alm & 6'b111110 & ~{6{fault_clr}})) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alm <= '0;
    end else begin
      r_alm <= {w_latch_nxt[5:1], w_pwr & ~|w_latch_nxt};
    end
  end
`else
  logic w_unused_clr;
  assign w_unused_clr = fault_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_alm <= '0;
    end else begin
      r_alm <= {w_live[5:1], w_pwr & ~|w_live};
    end
  end
`endif

  assign A1 = r_alm[ALM_RUN];
  assign A2 = r_alm[ALM_PRS];
  assign A3 = r_alm[ALM_LVL];
  assign A4 = r_alm[ALM_FLW];
  assign A5 = r_alm[ALM_TMP];
  assign A6 = r_alm[ALM_VIB];

endmodule

// File: tb/tb_industrial_pump_monitor.sv
// Bench for industrial_pump_monitor: directed scenarios plus random sensor traffic vs a window-based model.
module tb_industrial_pump_monitor;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  logic S1, S2, S3, S4, S5, S6;
  logic fault_clr;
  logic A1, A2, A3, A4, A5, A6;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [5:0] NORM    = 6'b001111;
  localparam logic [5:0] RUN_OK  = 6'b000001;

  industrial_pump_monitor #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst(rst),
    .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5), .S6(S6),
    .fault_clr(fault_clr),
    .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6)
  );

  always #5 clk = ~clk;

  logic [5:0] o_vec;
  assign o_vec = {A6, A5, A4, A3, A2, A1};

  // Model: a sensor's filtered value flips once DEB consecutive synchronised
  // samples (two cycles old) all disagree with it; outputs follow one edge later.
  logic [5:0] m_hs [0:DEB];
  logic [5:0] m_filt = '0;
  logic [4:0] m_lat  = '0;
  logic [5:0] m_exp  = '0;

  always @(posedge clk) begin
    logic       pwr;
    logic [4:0] lv;
    logic       same;
    if (rst) begin
      for (int j = 0; j <= DEB; j++) m_hs[j] = '0;
      m_filt = '0;
      m_lat  = '0;
      m_exp  = '0;
    end else begin
      pwr   = m_filt[0];
      lv[0] = pwr & ~m_filt[1];
      lv[1] = pwr & ~m_filt[2];
      lv[2] = pwr & ~m_filt[3];
      lv[3] = pwr &  m_filt[4];
      lv[4] = pwr &  m_filt[5];
`ifdef FAULT_LATCH_EN
      if (!pwr)           m_lat = '0;
      else if (fault_clr) m_lat = lv;
      else                m_lat = m_lat | lv;
      m_exp = {m_lat, pwr && (m_lat == 0)};
`else
      m_exp = {lv, pwr && (lv == 0)};
`endif
      for (int b = 0; b < 6; b++) begin
        same = 1'b1;
        for (int j = 1; j <= DEB; j++)
          if (m_hs[j][b] != m_hs[1][b]) same = 1'b0;
        if (same && (m_hs[1][b] != m_filt[b])) m_filt[b] = m_hs[1][b];
      end
      for (int j = DEB; j >= 1; j--) m_hs[j] = m_hs[j-1];
      m_hs[0] = {S6, S5, S4, S3, S2, S1};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got[5:0], exp[5:0], $time);
    end
  endtask

  task automatic drive(input logic [5:0] s);
    {S6, S5, S4, S3, S2, S1} = s;
  endtask

  // One clock cycle, ending at the falling edge with a model comparison.
  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("model", {26'd0, o_vec}, {26'd0, m_exp});
    end
  endtask

  initial begin
    logic [5:0] fv;
    logic [5:0] rv;
    int         hold;

    rst = 1'b1;
    fault_clr = 1'b0;
    drive(6'b000000);
    cyc(3);
    chk("reset", {26'd0, o_vec}, 32'd0);
    rst = 1'b0;
    drive(NORM);
    cyc(10);
    chk("normal", {26'd0, o_vec}, {26'd0, RUN_OK});

    for (int i = 1; i <= 5; i++) begin
      fv = NORM ^ (6'b1 << i);
      drive(fv);
      cyc(6);
      chk("fault_edge6", {26'd0, o_vec}, {26'd0, RUN_OK});
      cyc(1);
      chk("fault_edge7", {26'd0, o_vec}, {26'd0, 6'b1 << i});
      drive(NORM);
      cyc(10);
      chk("fault_recover", {26'd0, o_vec}, {26'd0, RUN_OK});
    end

    drive(6'b011100);
    cyc(6);
    chk("pwroff_edge6", {26'd0, o_vec}, {26'd0, RUN_OK});
    cyc(1);
    chk("pwroff_edge7", {26'd0, o_vec}, 32'd0);
    drive(NORM);
    cyc(10);
    chk("pwron", {26'd0, o_vec}, {26'd0, RUN_OK});

    drive(6'b001101);
    cyc(3);
    drive(NORM);
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      chk("glitch", {26'd0, o_vec}, {26'd0, RUN_OK});
    end

    drive(6'b000011);
    cyc(7);
    chk("multi", {26'd0, o_vec}, {26'd0, 6'b001100});
    rst = 1'b1;
    cyc(1);
    chk("rst_mid", {26'd0, o_vec}, 32'd0);
    rst = 1'b0;
    cyc(6);
    chk("requal_edge6", {26'd0, o_vec}, 32'd0);
    cyc(1);
    chk("requal_edge7", {26'd0, o_vec}, {26'd0, 6'b001100});
    drive(NORM);
    cyc(10);

`ifdef FAULT_LATCH_EN
    drive(NORM | 6'b010000);
    cyc(10);
    drive(NORM);
    cyc(12);
    chk("latch_hold", {26'd0, o_vec}, {26'd0, 6'b010000});
    drive(NORM | 6'b010000);
    cyc(10);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    cyc(1);
    chk("clr_while_live", {26'd0, o_vec}, {26'd0, 6'b010000});
    drive(NORM);
    cyc(10);
    fault_clr = 1'b1;
    cyc(1);
    fault_clr = 1'b0;
    chk("clr_after", {26'd0, o_vec}, {26'd0, RUN_OK});
`endif

    for (int t = 0; t < 120; t++) begin
      rv = 6'($urandom);
      if ($urandom_range(0, 2) != 0) rv = NORM ^ (6'b1 << $urandom_range(0, 5));
      drive(rv);
      hold = $urandom_range(1, 10);
      for (int k = 0; k < hold; k++) begin
        fault_clr = ($urandom_range(0, 7) == 0);
        rst       = ($urandom_range(0, 60) == 0);
        cyc(1);
      end
    end
    rst = 1'b0;
    fault_clr = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
